// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes 9-bit instruction words from fetch, buffers the
// decoded entries in a small FIFO and presents them to the ALU.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on the registered fill level and Reset, so
// there is no combinational path from out_ready to in_ready. out_valid
// depends only on the fill level; the head fields stay stable while
// out_valid is 1 and out_ready is 0.

package alu_issue_stage_pkg;
   typedef enum logic [2:0] {
      ADD  = 3'd0,
      LSH  = 3'd1,
      RSH  = 3'd2,
      XOR  = 3'd3,
      AND  = 3'd4,
      SUB  = 3'd5,
      CLR  = 3'd6,
      XORA = 3'd7
   } op_mne;
endpackage

module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   input  logic [8:0]       in_inst,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   output op_mne            out_op,
   output logic [2:0]       out_ra,
   output logic [2:0]       out_rb,
   output logic [2:0]       out_imm,
   output logic             out_use_imm,
   output logic             out_uses_rb,
   input  logic             out_ready,
   output logic [CNT_W-1:0] issue_count
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      op_mne      op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [2:0] imm;
      logic       use_imm;
      logic       uses_rb;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           last_q, last_d;
   entry_t           dec;
   entry_t           head;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic [CNT_W-1:0] issue_q, issue_d;
   logic             push, pop;

   // Decode the incoming word before it is stored; entries are kept decoded.
   always_comb begin
      dec.op      = op_mne'(in_inst[8:6]);
      dec.ra      = in_inst[5:3];
      dec.imm     = in_inst[2:0];
      dec.use_imm = (dec.op == LSH) || (dec.op == RSH);
      dec.uses_rb = !((dec.op == LSH) || (dec.op == RSH) || (dec.op == CLR));
      dec.rb      = dec.uses_rb ? in_inst[2:0] : 3'd0;
   end

   assign in_ready  = !Reset && (count_q < (PW+1)'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !Reset && !flush;

   // Head view: live head entry, or the last popped entry once empty.
   assign head        = out_valid ? mem_q[rd_ptr_q] : last_q;
   assign out_op      = head.op;
   assign out_ra      = head.ra;
   assign out_rb      = head.rb;
   assign out_imm     = head.imm;
   assign out_use_imm = head.use_imm;
   assign out_uses_rb = head.uses_rb;
   assign issue_count = issue_q;

   // Next-state for pointers, fill level, issue counter and hold register.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      issue_d  = issue_q;
      last_d   = last_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            issue_d  = issue_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         issue_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         issue_q  <= issue_d;
         last_q   <= last_d;
      end
   end

   // Entry storage; written only on an accepted push, never reset.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dec;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// all checked against a queue-based model of the stage.
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [8:0]       in_inst = '0;
   logic             in_ready;
   logic             flush = 1'b0;
   logic             out_valid;
   op_mne            out_op;
   logic [2:0]       out_ra, out_rb, out_imm;
   logic             out_use_imm, out_uses_rb;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] issue_count;

   alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_inst(in_inst),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
      .out_op(out_op), .out_ra(out_ra), .out_rb(out_rb), .out_imm(out_imm),
      .out_use_imm(out_use_imm), .out_uses_rb(out_uses_rb),
      .out_ready(out_ready), .issue_count(issue_count)
   );

   // clock / reset block
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0] op, ra, rb, imm;
      logic       use_imm, uses_rb;
   } ent_t;

   ent_t exp_q[$];
   ent_t last_exp;
   int   exp_issue = 0;
   bit   known = 0;
   int   checks = 0;
   int   failures = 0;

   function automatic ent_t model_decode(input logic [8:0] inst);
      ent_t e;
      bit   shift, no_rb;
      e.op    = inst[8:6];
      e.ra    = inst[5:3];
      e.imm   = inst[2:0];
      shift   = (e.op == 3'd1) || (e.op == 3'd2);
      no_rb   = shift || (e.op == 3'd6);
      e.use_imm = shift;
      e.uses_rb = !no_rb;
      e.rb    = no_rb ? 3'd0 : inst[2:0];
      return e;
   endfunction

   function automatic ent_t reset_ent();
      ent_t e;
      e.op = 3'd0; e.ra = 3'd0; e.rb = 3'd0; e.imm = 3'd0;
      e.use_imm = 1'b0; e.uses_rb = 1'b0;
      return e;
   endfunction

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic step(input logic rst, input logic iv, input logic [8:0] inst,
                       input logic fl, input logic ordy);
      bit   exp_ir, exp_ov, do_push, do_pop;
      ent_t h;
      @(negedge Clk);
      Reset = rst; in_valid = iv; in_inst = inst; flush = fl; out_ready = ordy;
      #1;
      exp_ir = !rst && (exp_q.size() < DEPTH);
      exp_ov = (exp_q.size() != 0);
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      if (known) begin
         h = exp_ov ? exp_q[0] : last_exp;
         check("out_valid",   {31'b0, out_valid},   {31'b0, exp_ov});
         check("out_op",      {29'b0, out_op},      {29'b0, h.op});
         check("out_ra",      {29'b0, out_ra},      {29'b0, h.ra});
         check("out_rb",      {29'b0, out_rb},      {29'b0, h.rb});
         check("out_imm",     {29'b0, out_imm},     {29'b0, h.imm});
         check("out_use_imm", {31'b0, out_use_imm}, {31'b0, h.use_imm});
         check("out_uses_rb", {31'b0, out_uses_rb}, {31'b0, h.uses_rb});
         check("issue_count", {28'b0, issue_count}, exp_issue);
      end
      do_push = iv && exp_ir;
      do_pop  = exp_ov && ordy;
      @(posedge Clk);
      if (rst) begin
         exp_q.delete();
         exp_issue = 0;
         last_exp  = reset_ent();
         known     = 1;
      end else if (fl) begin
         exp_q.delete();
      end else begin
         if (do_pop) begin
            last_exp  = exp_q.pop_front();
            exp_issue = (exp_issue + 1) % (1 << CNT_W);
         end
         if (do_push) exp_q.push_back(model_decode(inst));
      end
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h0, 1'b0, ordy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 9'h1ff, 1'b0, 1'b1);
      idle(1, 1'b0);

      // decode: LSH ra=3 imm=5, then SUB ra=2 rb=6
      step(1'b0, 1'b1, 9'b001_011_101, 1'b0, 1'b1);
      step(1'b0, 1'b1, 9'b101_010_110, 1'b0, 1'b1);
      idle(2, 1'b1);

      // backpressure: fill, third push ignored, then drain
      step(1'b0, 1'b1, 9'b000_001_010, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9'b011_100_101, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9'b100_111_011, 1'b0, 1'b0);
      idle(3, 1'b1);

      // streaming opcodes 0..7
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, {i[2:0], i[2:0], 3'(7 - i)}, 1'b0, 1'b1);
      idle(2, 1'b1);

      // flush with two entries held, input and head offered in flush cycle
      step(1'b0, 1'b1, 9'b011_001_001, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9'b100_010_010, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9'b101_011_011, 1'b1, 1'b1);
      idle(2, 1'b1);

      // mid-operation reset with two buffered entries
      step(1'b0, 1'b1, 9'b111_101_001, 1'b0, 1'b0);
      step(1'b0, 1'b1, 9'b110_110_010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 9'b000_000_001, 1'b0, 1'b1);
      idle(2, 1'b1);

      // long stream to wrap the 4-bit issue counter
      for (int i = 0; i < 20; i++)
         step(1'b0, 1'b1, 9'($urandom_range(0, 511)), 1'b0, 1'b1);
      idle(2, 1'b1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 70,
              9'($urandom_range(0, 511)),
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 60);
      end
      idle(3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the ALU.
- Accepts 9-bit instruction words from fetch over a valid/ready handshake and decodes the 3-bit opcode into the op_mne enum from the Definitions package (ADD=0, LSH=1, RSH=2, XOR=3, AND=4, SUB=5, CLR=6, XORA=7).
- Decodes operand fields, buffers up to DEPTH decoded entries in a skid FIFO, and presents them to the ALU over a second valid/ready handshake.
- Also supports flush and counts issued operations.

Parameters:
- DEPTH, 2, number of decoded entries buffered (2 or 4; power of two).
- CNT_W, 16, width of issue counter.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_inst  in  9  instruction: [8:6] opcode, [5:3] ra, [2:0] rb/imm.
- in_ready  out  1  stage can accept an instruction this cycle.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry valid.
- out_op  out  op_mne (3)  decoded ALU operation.
- out_ra  out  3  source/destination register address.
- out_rb  out  3  second source register address; 0 when use_imm.
- out_imm  out  3  shift amount, copied from inst[2:0].
- out_use_imm  out  1  1 for LSH, RSH.
- out_uses_rb  out  1  1 for ADD, XOR, AND, SUB, XORA; 0 for LSH, RSH, CLR.
- out_ready  in  1  ALU accepts head entry.
- issue_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values, applied at the clock edge where Reset=1:
  - FIFO count=0, read/write pointers=0.
  - out_valid=0; out_op=ADD; out_ra, out_rb, out_imm=0; out_use_imm=0; out_uses_rb=0.
  - in_ready=0 during the Reset cycle, then 1 from the first cycle after Reset deasserts.
  - issue_count=0.
  - Reset asserted mid-operation drops all buffered entries. No handshake completes in a Reset cycle, and issue_count does not increment in it.
- Decode:
  - Combinational on in_inst, before the FIFO write; stored fields are already decoded.
  - Opcode maps 1:1 onto op_mne.
  - out_rb is forced to 0 for LSH, RSH and CLR.
  - out_imm is always inst[2:0].
- Push: in_valid & in_ready at an edge writes one entry. in_ready = (count < DEPTH), driven from registered count (no combinational path from out_ready).
- Pop: out_valid & out_ready at an edge removes the head entry and increments issue_count. issue_count wraps modulo 2^CNT_W.
- Output view: out_valid = (count != 0). out_* fields show the head entry and stay stable while out_valid & !out_ready. When count==0, fields hold the last popped values (don't-care to the ALU).
- Latency: an instruction pushed into an empty stage appears on out_valid the next cycle. There is no combinational bypass.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When full, in_ready=0, so a pop alone occurs. in_ready rises the following cycle.
- Empty: pop is impossible since out_valid=0; out_ready is ignored.
- Full: in_valid is ignored, and in_inst is not captured.
- Pointers wrap modulo DEPTH.
- Flush (priority below Reset, above push/pop):
  - Count=0, pointers=0, out_valid=0 the next cycle.
  - An input offered in the flush cycle is dropped.
  - A head entry offered in the flush cycle does not count as issued.
  - issue_count is preserved.
- Order: entries leave in acceptance order, with no reordering or duplication.

Test Plan:
- Reset → out_valid=0, issue_count=0, out_op=ADD. One cycle after Reset deasserts, in_ready=1.
- Decode:
  - Push 9'b001_011_101 (LSH ra=3 imm=5), out_ready=1 → next cycle out_op=LSH, out_ra=3, out_rb=0, out_imm=5, out_use_imm=1, out_uses_rb=0.
  - Push 9'b101_010_110 (SUB) → out_ra=2, out_rb=6, out_uses_rb=1, out_use_imm=0.
- Backpressure, DEPTH=2: out_ready=0, push ADD then XOR → in_ready=0 after the 2nd push, and a 3rd push (AND) is ignored. Raise out_ready → ADD then XOR each issue on successive cycles; in_ready returns to 1; issue_count=2.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with opcodes 0..7 → outputs ADD, LSH, RSH, XOR, AND, SUB, CLR, XORA in order, one per cycle after 1-cycle latency; issue_count=8. CLR shows out_rb=0, out_uses_rb=0.
- Flush: hold 2 entries, assert flush with in_valid=1 and out_ready=1 → next cycle out_valid=0, count=0, issue_count unchanged, flush-cycle input absent.
- Mid-operation reset and wrap:
  - Reset with 2 buffered entries → all dropped, issue_count=0.
  - Separately, CNT_W=4 with 17 issues → issue_count=1.
